// File: rtl/ps2_rx_if.sv
// ps2_rx_if: host-side handshake bundle of the PS/2 receiver.
//   rx_en        - receive enable; the controlling logic drives it.
//   rx_done_tick - one-clk strobe when a valid byte arrives; the receiver drives it.
//   dout         - last valid received byte; the receiver drives it.
// The receiver connects through the slave modport and the consumer through master.
`timescale 1ns/1ps
interface ps2_rx_if;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;

  modport master (output rx_en, input rx_done_tick, input dout);
  modport slave  (input rx_en, output rx_done_tick, output dout);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host serial receiver.
// The PS/2 clock and data pins are synchronised into clk. The PS/2 clock is
// deglitched by a FILTER_LEN-sample majority-free filter: its level changes only
// after FILTER_LEN identical samples. Each falling edge of the filtered clock
// samples one bit of an 11-bit frame (start, 8 data LSB-first, odd parity, stop).
// A frame with a good stop bit and odd parity updates dout and pulses
// rx_done_tick for one clk.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   ps2d  - raw PS/2 data pin (asynchronous)
//   ps2c  - raw PS/2 clock pin (asynchronous)
//   rx    - ps2_rx_if.slave: rx_en in, rx_done_tick / dout out
`timescale 1ns/1ps
module ps2_rx #(
  parameter int FILTER_LEN = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ps2d,
  input  logic     ps2c,
  ps2_rx_if.slave  rx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Start low, stop high, odd parity across data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] f);
    return (~f[0]) & f[10] & (^f[9:1]);
  endfunction

  logic                  ps2c_meta_q, ps2c_meta_d;
  logic                  ps2c_sync_q, ps2c_sync_d;
  logic                  ps2d_meta_q, ps2d_meta_d;
  logic                  ps2d_sync_q, ps2d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  state_e                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [10:0]           b_q, b_d;
  logic [7:0]            dout_q, dout_d;
  logic                  tick_q, tick_d;
  logic                  fall_edge;
  logic [10:0]           b_shift;

  // State register: every flop in the block, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      filt_q      <= {FILTER_LEN{1'b1}};
      fclk_q      <= 1'b1;
      state_q     <= IDLE;
      n_q         <= 4'd0;
      b_q         <= 11'd0;
      dout_q      <= 8'h00;
      tick_q      <= 1'b0;
    end else begin
      ps2c_meta_q <= ps2c_meta_d;
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_meta_q <= ps2d_meta_d;
      ps2d_sync_q <= ps2d_sync_d;
      filt_q      <= filt_d;
      fclk_q      <= fclk_d;
      state_q     <= state_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      tick_q      <= tick_d;
    end
  end

  // Input conditioning: synchronisers, clock filter, falling-edge detect.
  always_comb begin
    ps2c_meta_d = ps2c;
    ps2c_sync_d = ps2c_meta_q;
    ps2d_meta_d = ps2d;
    ps2d_sync_d = ps2d_meta_q;
    filt_d      = {ps2c_sync_q, filt_q[FILTER_LEN-1:1]};
    if (filt_q == {FILTER_LEN{1'b1}}) begin
      fclk_d = 1'b1;
    end else if (filt_q == {FILTER_LEN{1'b0}}) begin
      fclk_d = 1'b0;
    end else begin
      fclk_d = fclk_q;
    end
    fall_edge = fclk_q & ~fclk_d;
    b_shift   = {ps2d_sync_q, b_q[10:1]};
  end

  // Next-state logic: frame sequencing and bit collection.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        // Only a low data line at a clock fall while enabled is a start bit.
        if (fall_edge && rx.rx_en && !ps2d_sync_q) begin
          b_d     = b_shift;
          n_d     = 4'd9;
          state_d = DPS;
        end else begin
          state_d = IDLE;
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_d = b_shift;
          if (n_q == 4'd0) begin
            state_d = LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else begin
          state_d = DPS;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        n_d     = 4'd0;
        b_d     = 11'd0;
      end
    endcase
  end

  // Output logic: the verdict is taken from the frame as it will stand after
  // the stop-bit shift, so the registered tick lands in the LOAD cycle and
  // dout changes on the same edge.
  always_comb begin
    tick_d = 1'b0;
    dout_d = dout_q;
    case (state_q)
      DPS: begin
        if (fall_edge && (n_q == 4'd0) && frame_ok(b_shift)) begin
          tick_d = 1'b1;
          dout_d = b_shift[8:1];
        end else begin
          tick_d = 1'b0;
          dout_d = dout_q;
        end
      end
      IDLE, LOAD: begin
        tick_d = 1'b0;
        dout_d = dout_q;
      end
      default: begin
        tick_d = 1'b0;
        dout_d = dout_q;
      end
    endcase
  end

  assign rx.rx_done_tick = tick_q;
  assign rx.dout         = dout_q;

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
module tb_ps2_rx;

  logic clk;
  logic reset;
  logic ps2d;
  logic ps2c;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ps2d  (ps2d),
    .ps2c  (ps2c),
    .rx    (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         tick_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_dout = 8'h00;
  logic       prev_tick = 1'b0;
  realtime    last_fall_t = 0;
  realtime    tick_t = 0;

  // Scoreboard: every tick pops one expected byte and checks dout and timing.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.rx_done_tick) begin
        logic [7:0] e;
        tick_cnt++;
        tick_t = $realtime;
        checks++;
        assert (prev_tick === 1'b0)
        else begin errors++; $error("FAIL tick_twice got %0b expected 0", prev_tick); end
        checks++;
        assert (exp_q.size() > 0)
        else begin errors++; $error("FAIL unexpected_tick got dout %h expected no tick", bus.dout); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (bus.dout === e)
          else begin errors++; $error("FAIL tick_dout got %h expected %h", bus.dout, e); end
          checks++;
          assert ((tick_t - last_fall_t >= 36.0) && (tick_t - last_fall_t <= 60.0))
          else begin errors++; $error("FAIL tick_latency got %0t ns expected 36..60 ns after last ps2c fall", tick_t - last_fall_t); end
        end
      end
      prev_tick = bus.rx_done_tick;
    end else begin
      prev_tick = 1'b0;
    end
  end

  task automatic send_bits(input logic [7:0] data, input logic par_err, input logic stop_bit,
                           input int n_bits, input int glitch_bit, input int drop_en_bit);
    logic [10:0] f;
    f = {stop_bit, (~^data) ^ par_err, data, 1'b0};
    for (int i = 0; i < n_bits; i++) begin
      ps2d = f[i];
      #25;
      ps2c = 1'b0;
      last_fall_t = $realtime;
      #50;
      ps2c = 1'b1;
      #25;
      if (i == glitch_bit) begin
        #40; ps2c = 1'b0; #8; ps2c = 1'b1; #40;
      end
      if (i == drop_en_bit) bus.rx_en = 1'b0;
    end
    ps2d = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input logic par_err,
                           input logic stop_bit, input int glitch_bit, input int drop_en_bit,
                           input logic expect_tick);
    int t0;
    int want;
    t0 = tick_cnt;
    want = expect_tick ? 1 : 0;
    if (expect_tick) begin
      exp_q.push_back(data);
      model_dout = data;
    end
    send_bits(data, par_err, stop_bit, 11, glitch_bit, drop_en_bit);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    assert (tick_cnt - t0 === want)
    else begin errors++; $error("FAIL %s_ticks got %0d expected %0d", tag, tick_cnt - t0, want); end
    checks++;
    assert (exp_q.size() === 0)
    else begin errors++; $error("FAIL %s_pending got %0d expected 0", tag, exp_q.size()); exp_q.delete(); end
    checks++;
    assert (bus.dout === model_dout)
    else begin errors++; $error("FAIL %s_dout got %h expected %h", tag, bus.dout, model_dout); end
    checks++;
    assert (bus.rx_done_tick === 1'b0)
    else begin errors++; $error("FAIL %s_tick_idle got %b expected 0", tag, bus.rx_done_tick); end
  endtask

  initial begin
    int t0;
    reset = 1'b0;
    ps2c = 1'b1;
    ps2d = 1'b1;
    bus.rx_en = 1'b0;

    // Reset held.
    repeat (5) @(posedge clk);
    #1;
    checks++;
    assert (bus.dout === 8'h00)
    else begin errors++; $error("FAIL rst_dout got %h expected 00", bus.dout); end
    checks++;
    assert (bus.rx_done_tick === 1'b0)
    else begin errors++; $error("FAIL rst_tick got %b expected 0", bus.rx_done_tick); end

    // Release reset: still idle.
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    assert (tick_cnt === 0)
    else begin errors++; $error("FAIL post_rst_ticks got %0d expected 0", tick_cnt); end
    checks++;
    assert (bus.dout === 8'h00)
    else begin errors++; $error("FAIL post_rst_dout got %h expected 00", bus.dout); end

    // Idle glitch on ps2c.
    bus.rx_en = 1'b1;
    #20; ps2c = 1'b0; #8; ps2c = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    assert (tick_cnt === 0)
    else begin errors++; $error("FAIL idle_glitch_ticks got %0d expected 0", tick_cnt); end

    run_frame("valid_1c",   8'h1C, 1'b0, 1'b1, -1, -1, 1'b1);
    run_frame("par_err",    8'h1C, 1'b1, 1'b1, -1, -1, 1'b0);
    run_frame("stop_err",   8'h1C, 1'b0, 1'b0, -1, -1, 1'b0);
    bus.rx_en = 1'b0;
    run_frame("disabled",   8'h1C, 1'b0, 1'b1, -1, -1, 1'b0);
    bus.rx_en = 1'b1;
    run_frame("valid_f0",   8'hF0, 1'b0, 1'b1, -1, -1, 1'b1);
    run_frame("mid_glitch", 8'h1C, 1'b0, 1'b1,  4, -1, 1'b1);
    run_frame("en_drop",    8'hA5, 1'b0, 1'b1, -1,  3, 1'b1);
    bus.rx_en = 1'b1;

    // Reset after 5 falling edges of a frame.
    t0 = tick_cnt;
    send_bits(8'h33, 1'b0, 1'b1, 5, -1, -1);
    reset = 1'b0;
    #3;
    model_dout = 8'h00;
    checks++;
    assert (bus.dout === 8'h00)
    else begin errors++; $error("FAIL midrst_dout got %h expected 00", bus.dout); end
    checks++;
    assert (bus.rx_done_tick === 1'b0)
    else begin errors++; $error("FAIL midrst_tick got %b expected 0", bus.rx_done_tick); end
    #20;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    assert (tick_cnt === t0)
    else begin errors++; $error("FAIL midrst_ticks got %0d expected %0d", tick_cnt, t0); end
    run_frame("after_rst_5a", 8'h5A, 1'b0, 1'b1, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
